// File: rtl/drum_pkg.sv
// Shared definitions for the drum sensor encoder: code layout, FSM states,
// and the pad priority helper.
package drum_pkg;

    localparam int CODE_W     = 7;
    localparam int BIT_START  = 0;
    localparam int BIT_STATIC = 1;
    localparam int BIT_PAD0   = 2;
    localparam int PAD_BITS   = CODE_W - BIT_PAD0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        LOCK  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Index of the lowest set pad; pad 0 has the highest priority.
    function automatic logic [2:0] lowest_pad(input logic [PAD_BITS-1:0] pads);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = PAD_BITS - 1; k >= 0; k--) begin
            if (pads[k]) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/drum_sensor_encoder_sync_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced
// output only flips after DEB_CYCLES consecutive differing synced samples.
module sync_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_db
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous raw input into the clk_sys domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count differing samples; flip on the last one, clear on any match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 != r_db) begin
            if (r_cnt == CNT_LAST) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/drum_sensor_encoder.sv
// Drum sensor encoder: debounces pads and start, arbitrates them and drives
// the registered 7-bit sensor code for the paint FSM.
//
// state | meaning
// IDLE  | nothing owns the code; arbitrate start and pads
// START | one-cycle start code, static band bit suppressed
// LOCK  | pad r_lock_idx owns the pad bits until it releases
// GAP   | one cycle with no pad bit; re-arbitrates straight into a held pad
//         so consecutive band codes are separated by exactly one empty cycle
module drum_sensor_encoder
    import drum_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int NUM_PADS   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_PADS-1:0] pad_raw,
    input  logic                start_raw,
    input  logic                band_active,
    output logic [CODE_W-1:0]   entrada,
    output logic                pad_locked
);

    logic [NUM_PADS-1:0] w_pad_db;
    logic                w_start_db;
    logic                w_start_rise;
    logic                w_any_pad;
    state_t              w_next_state;
    logic [2:0]          w_next_idx;
    logic [NUM_PADS-1:0] w_pad_bits;
    logic [CODE_W-1:0]   w_next_code;

    state_t              r_state;
    logic [2:0]          r_lock_idx;
    logic                r_start_db_d;
    logic [CODE_W-1:0]   r_entrada;
    logic                r_pad_locked;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad_deb
        sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pad_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .i_raw   (pad_raw[g]),
            .o_db    (w_pad_db[g])
        );
    end

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (start_raw),
        .o_db    (w_start_db)
    );

    // Next-state arbitration and the code that the next state will drive.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_lock_idx;
        w_start_rise = w_start_db & ~r_start_db_d;
        w_any_pad    = |w_pad_db;
        case (r_state)
            IDLE, GAP: begin
                if (w_start_rise && !w_any_pad) begin
                    w_next_state = START;
                end else if (w_any_pad) begin
                    w_next_state = LOCK;
                    w_next_idx   = lowest_pad(w_pad_db);
                end else begin
                    w_next_state = IDLE;
                end
            end
            START: w_next_state = IDLE;
            LOCK: begin
                if (!w_pad_db[r_lock_idx]) w_next_state = GAP;
            end
            default: w_next_state = IDLE;
        endcase

        w_pad_bits  = (w_next_state == LOCK) ? (NUM_PADS'(1) << w_next_idx) : '0;
        w_next_code = {w_pad_bits,
                       band_active & (w_next_state != START),
                       w_next_state == START};
    end

    // State, lock owner, start edge history and the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_lock_idx   <= 3'd0;
            r_start_db_d <= 1'b0;
            r_entrada    <= '0;
            r_pad_locked <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_lock_idx   <= w_next_idx;
            r_start_db_d <= w_start_db;
            r_entrada    <= w_next_code;
            r_pad_locked <= (w_next_state == LOCK);
        end
    end

    assign entrada    = r_entrada;
    assign pad_locked = r_pad_locked;

endmodule

// File: tb/tb_drum_sensor_encoder.sv
// Directed bench for drum_sensor_encoder with DEB_CYCLES=4 (7-edge latency).
module tb_drum_sensor_encoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] pad_raw;
    logic       start_raw;
    logic       band_active;
    logic [6:0] entrada;
    logic       pad_locked;

    int n_tests = 0;
    int n_fail  = 0;

    drum_sensor_encoder #(.DEB_CYCLES(4), .NUM_PADS(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pad_raw     (pad_raw),
        .start_raw   (start_raw),
        .band_active (band_active),
        .entrada     (entrada),
        .pad_locked  (pad_locked)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        n_tests++;
        assert (entrada === exp) else begin
            n_fail++;
            $error("FAIL %s: entrada=%b expected %b", tag, entrada, exp);
        end
    endtask

    task automatic chk_lock(input string tag, input logic exp);
        n_tests++;
        assert (pad_locked === exp) else begin
            n_fail++;
            $error("FAIL %s: pad_locked=%b expected %b", tag, pad_locked, exp);
        end
    endtask

    task automatic chk_onehot(input string tag);
        logic [6:0] mask;
        mask = 7'b1111101;
        n_tests++;
        assert ($countones(entrada & mask) <= 1) else begin
            n_fail++;
            $error("FAIL %s: entrada=%b expected at most one of bits 0,2..6", tag, entrada);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        pad_raw     = 5'b11111;
        start_raw   = 1'b0;
        band_active = 1'b0;

        // Reset with all pads held; lowest pad wins after release.
        tick(3);
        chk("reset_entrada", 7'b0000000);
        chk_lock("reset_locked", 1'b0);
        reset_n = 1'b1;
        tick(6);
        chk("rel_edge6", 7'b0000000);
        tick(1);
        chk("rel_edge7_pad0", 7'b0000100);
        chk_lock("rel_edge7_locked", 1'b1);

        // Async reset mid-LOCK, pads still held must debounce again.
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("async_clear", 7'b0000000);
        chk_lock("async_clear_locked", 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        chk("rerel_edge6", 7'b0000000);
        tick(1);
        chk("rerel_edge7", 7'b0000100);
        pad_raw = 5'b00000;
        tick(6);
        chk("allrel_edge6", 7'b0000100);
        tick(1);
        chk("allrel_gap", 7'b0000000);
        chk_lock("allrel_gap_locked", 1'b0);
        tick(4);

        // Start held 20 cycles: one pulse only.
        start_raw = 1'b1;
        tick(6);
        chk("start_edge6", 7'b0000000);
        tick(1);
        chk("start_pulse", 7'b0000001);
        tick(1);
        chk("start_after", 7'b0000000);
        tick(12);
        chk("start_held", 7'b0000000);
        start_raw = 1'b0;
        tick(10);
        start_raw = 1'b1;
        tick(7);
        chk("repress_pulse", 7'b0000001);
        tick(1);
        chk("repress_after", 7'b0000000);
        start_raw = 1'b0;
        tick(10);

        // Pad2 held 10 cycles then released.
        pad_raw = 5'b00100;
        tick(6);
        chk("pad2_edge6", 7'b0000000);
        tick(1);
        chk("pad2_edge7", 7'b0010000);
        tick(3);
        chk("pad2_held", 7'b0010000);
        chk_lock("pad2_locked", 1'b1);
        pad_raw = 5'b00000;
        tick(6);
        chk("pad2_rel_edge6", 7'b0010000);
        tick(1);
        chk("pad2_gap", 7'b0000000);
        chk_lock("pad2_gap_locked", 1'b0);
        tick(1);
        chk("pad2_idle", 7'b0000000);
        tick(4);

        // 3-cycle glitch on pad1 is rejected.
        pad_raw = 5'b00010;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) pad_raw = 5'b00000;
            tick(1);
            chk($sformatf("glitch_%0d", i), 7'b0000000);
        end

        // Pad0 and pad3 together, then pad0 released: one-cycle gap, pad3.
        pad_raw = 5'b01001;
        tick(7);
        chk("dual_pad0", 7'b0000100);
        tick(3);
        pad_raw = 5'b01000;
        tick(6);
        chk("dual_rel_edge6", 7'b0000100);
        tick(1);
        chk("dual_gap", 7'b0000000);
        tick(1);
        chk("dual_pad3", 7'b0100000);
        chk_lock("dual_pad3_locked", 1'b1);
        pad_raw = 5'b00000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk_onehot($sformatf("dual_onehot_%0d", i));
        end
        chk("dual_idle", 7'b0000000);

        // Static band bit with pad2 and during a start pulse.
        band_active = 1'b1;
        tick(1);
        chk("band_idle", 7'b0000010);
        pad_raw = 5'b00100;
        tick(7);
        chk("band_pad2", 7'b0010010);
        pad_raw = 5'b00000;
        tick(10);
        chk("band_after_pad", 7'b0000010);
        start_raw = 1'b1;
        tick(7);
        chk("band_start", 7'b0000001);
        tick(1);
        chk("band_start_after", 7'b0000010);
        start_raw = 1'b0;
        tick(10);

        // Start pressed while pad1 is held is dropped.
        pad_raw = 5'b00010;
        tick(7);
        chk("hold_pad1", 7'b0001010);
        start_raw = 1'b1;
        tick(8);
        chk("start_dropped", 7'b0001010);
        pad_raw = 5'b00000;
        tick(7);
        chk("drop_gap", 7'b0000010);
        tick(3);
        chk("drop_no_queue", 7'b0000010);
        start_raw = 1'b0;
        band_active = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drum_sensor_encoder.md
Name: drum_sensor_encoder

Overview:
- Front end of the paint path: turns five raw drum-pad contacts, a start button and the scroller's hit-window flag into the 7-bit sensor code consumed by the paint state machine.
- Synchronises and debounces every raw input, then arbitrates pads so only codes the paint FSM accepts are ever driven.
- Guarantees: a clean one-cycle start code; exactly one band bit at a time; a one-cycle gap between band switches.

Parameters:
- DEB_CYCLES, 16: consecutive stable synced samples required before a debounced input changes (min 2).
- NUM_PADS, 5: number of drum pads; fixed at 5 by the 7-bit code.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pad_raw  in  5  raw drum contacts, bit k = pad k, active high, asynchronous
- start_raw  in  1  raw start button, active high, asynchronous
- band_active  in  1  synchronous; a note is inside the static hit window
- entrada  out  7  sensor code: bit0 start, bit1 static band, bits2..6 = pad0..pad4
- pad_locked  out  1  high while a pad owns bits2..6

Behaviour:
- Reset (reset_n low, async): entrada=0, pad_locked=0, FSM=IDLE, all sync flops, debounced values and counters = 0. Released synchronously on the next clk edge.
- Sync: each raw input passes a 2-flop synchroniser.
- Debounce, per input:
  - If synced != debounced, the counter increments.
  - When the counter reaches DEB_CYCLES-1 with a still-differing sample, debounced flips and the counter clears.
  - Any matching sample clears the counter.
  - Pulses shorter than DEB_CYCLES cycles are rejected.
- Latency: raw edge to entrada change = DEB_CYCLES+3 clk edges, exact.
- entrada is fully registered; no combinational path from inputs.
- FSM states and transitions:
  - IDLE: start_db rising edge and no pad_db set -> START. Otherwise, any pad_db set -> LOCK on the lowest-index set pad.
  - START: drive entrada=7'b0000001 for exactly one cycle, all other bits zero, bit1 suppressed -> IDLE. A start held high produces no repeat until it is released and re-pressed.
  - LOCK(k): entrada[k+2]=1, other pad bits 0, pad_locked=1. Other pads pressed meanwhile are ignored. When pad_db[k] falls -> GAP.
  - GAP: pad bits 0, pad_locked=0 for one cycle -> IDLE. A still-held pad is re-arbitrated the next cycle and re-locks.
- bit1 = registered band_active in IDLE, LOCK and GAP; forced 0 in START.
- Simultaneous events:
  - Start rising edge while a pad is held: start is dropped, not queued.
  - Two pads debouncing high on the same cycle: the lowest index wins.
- Invariant: at most one of bits0, 2..6 is set in any cycle.
- Reset mid-LOCK: entrada clears immediately (async). Pads held across reset must pass the full debounce again.

Decomposition:
- Shared package drum_pkg holds:
  - bit-index constants: BIT_START=0, BIT_STATIC=1, BIT_PAD0=2
  - the FSM state enum: IDLE, START, LOCK, GAP
  - a localparam for code width, 7
- One sub-module, sync_debounce (2-flop sync + counter, parameter DEB_CYCLES), instantiated 6 times.
- The top holds the arbitration FSM and the output register.

Test Plan (DEB_CYCLES=4):
- reset_n low with pads high, then released -> entrada=0; pad appears exactly 7 edges after it is stable.
- start_raw held high 20 cycles -> a single cycle entrada=0000001, then 0000000. Re-press -> one more pulse.
- pad_raw=00100 held 10 cycles, then released -> entrada=0010000 from edge 7. After release: one GAP cycle 0000000, then IDLE.
- pad_raw 3-cycle glitch on pad1 -> entrada stays 0000000 throughout.
- pad0 held, pad3 pressed at the same time, pad0 released -> 0000100 while pad0 held, then gap 0000000, then 0100000; never two band bits together.
- band_active=1 with pad2 held -> entrada=0010010. During a start pulse -> entrada=0000001 exactly.
